// File: rtl/weight_buffer_loader_18_9_42_2_if.sv
// ---------------------------------------------------------------------------
// weight_buffer_loader_18_9_42_2_if
//
// Bundles the control, weight-stream and dual-bank RAM write signals of the
// weight buffer loader.
//   start              load request (one cycle)
//   in_valid/in_ready  weight stream handshake, in_data carries the weight
//   wr_en_b/addr_b/data_b  write port towards RAM bank b (b = 0, 1)
//   busy, done         load status
//   checksum           running sum of accepted weights (0 when not built)
// Modports:
//   master : stream source / RAM side (drives start, in_valid, in_data)
//   slave  : the loader itself
// ---------------------------------------------------------------------------
interface weight_buffer_loader_18_9_42_2_if #(
    parameter int DATA_WIDTH = 18,
    parameter int LANES      = 9,
    parameter int ADDR_WIDTH = 12
);
    localparam int WORD_WIDTH = DATA_WIDTH * LANES;

    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  wr_en_0;
    logic                  wr_en_1;
    logic [ADDR_WIDTH-1:0] wr_addr_0;
    logic [ADDR_WIDTH-1:0] wr_addr_1;
    logic [WORD_WIDTH-1:0] wr_data_0;
    logic [WORD_WIDTH-1:0] wr_data_1;
    logic                  busy;
    logic                  done;
    logic [31:0]           checksum;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, wr_en_0, wr_en_1, wr_addr_0, wr_addr_1,
               wr_data_0, wr_data_1, busy, done, checksum
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, wr_en_0, wr_en_1, wr_addr_0, wr_addr_1,
               wr_data_0, wr_data_1, busy, done, checksum
    );
endinterface

// File: rtl/weight_buffer_loader_18_9_42_2.sv
// ---------------------------------------------------------------------------
// weight_buffer_loader_18_9_42_2
//
// Streaming writer filling the two weight-buffer RAM banks. Weights arrive
// one per handshake, nine are packed into a 162-bit word (lane 0 in the low
// bits), and each finished word is written with a one-cycle strobe. Words
// alternate bank 0 / bank 1 per row: bank 0 row r goes to address r, bank 1
// row r goes to address r + ROWS, so a single read index addresses both
// banks at offsets 0 and ROWS.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave modport of weight_buffer_loader_18_9_42_2_if
//          (start, in_valid/in_ready/in_data, wr_en/addr/data per bank,
//           busy, done, checksum)
//
// Optional feature: define WEIGHT_LOADER_CHECKSUM_EN to build a 32-bit
// mod-2^32 accumulator of all accepted weights; otherwise checksum is 0.
// ---------------------------------------------------------------------------
module weight_buffer_loader_18_9_42_2 #(
    parameter int DATA_WIDTH = 18,
    parameter int LANES      = 9,
    parameter int ROWS       = 42,
    parameter int ADDR_WIDTH = 12
) (
    input  logic clk,
    input  logic rst_n,
    weight_buffer_loader_18_9_42_2_if.slave bus
);
    localparam int WORD_WIDTH = DATA_WIDTH * LANES;
    localparam int LANE_W     = $clog2(LANES);
    localparam int ROW_W      = $clog2(ROWS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [LANE_W-1:0]     lane_reg;
    logic                  bank_reg;
    logic [ROW_W-1:0]      row_reg;

    logic                  wr_en_0_reg, wr_en_1_reg;
    logic [ADDR_WIDTH-1:0] wr_addr_0_reg, wr_addr_1_reg;
    logic [WORD_WIDTH-1:0] wr_data_0_reg, wr_data_1_reg;

    logic [WORD_WIDTH-1:0] word_next;
    logic                  load_start;
    logic                  accept;
    logic                  last_lane;
    logic                  last_weight;

    assign load_start  = (state_reg == IDLE) && bus.start;
    assign accept      = (state_reg == LOAD) && bus.in_valid;
    assign last_lane   = (lane_reg == LANE_W'(LANES - 1));
    assign last_weight = accept && last_lane && bank_reg &&
                         (row_reg == ROW_W'(ROWS - 1));

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = LOAD;
            LOAD:    if (last_weight) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Lane / bank / row counters. The row only advances after the bank-1
    // word of that row, which yields the 0, ROWS, 1, ROWS+1, ... order.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_reg <= '0;
            bank_reg <= 1'b0;
            row_reg  <= '0;
        end else if (load_start) begin
            lane_reg <= '0;
            bank_reg <= 1'b0;
            row_reg  <= '0;
        end else if (accept) begin
            if (last_lane) begin
                lane_reg <= '0;
                bank_reg <= ~bank_reg;
                if (bank_reg) begin
                    row_reg <= row_reg + ROW_W'(1);
                end
            end else begin
                lane_reg <= lane_reg + LANE_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Packing: lanes 0..LANES-2 are captured into holding registers; the
    // final lane is taken straight from in_data so the completed word can
    // be registered on the same edge the last weight is accepted.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LANES - 1; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] data_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                end else if (accept && (lane_reg == LANE_W'(gi))) begin
                    data_reg <= bus.in_data;
                end
            end

            assign word_next[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg;
        end
    endgenerate

    assign word_next[(LANES-1)*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;

    // ------------------------------------------------------------------
    // Write ports. Strobes last one cycle; address/data hold otherwise,
    // and only the bank being written is updated.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_0_reg   <= 1'b0;
            wr_en_1_reg   <= 1'b0;
            wr_addr_0_reg <= '0;
            wr_addr_1_reg <= '0;
            wr_data_0_reg <= '0;
            wr_data_1_reg <= '0;
        end else begin
            wr_en_0_reg <= accept && last_lane && !bank_reg;
            wr_en_1_reg <= accept && last_lane && bank_reg;
            if (accept && last_lane && !bank_reg) begin
                wr_addr_0_reg <= ADDR_WIDTH'(row_reg);
                wr_data_0_reg <= word_next;
            end
            if (accept && last_lane && bank_reg) begin
                wr_addr_1_reg <= ADDR_WIDTH'(row_reg) + ADDR_WIDTH'(ROWS);
                wr_data_1_reg <= word_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional checksum
    // ------------------------------------------------------------------
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [31:0] checksum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_reg <= '0;
        end else if (load_start) begin
            checksum_reg <= '0;
        end else if (accept) begin
            checksum_reg <= checksum_reg + 32'(bus.in_data);
        end
    end

    assign bus.checksum = checksum_reg;
`else
    assign bus.checksum = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = (state_reg == LOAD);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = (state_reg == DONE);
    assign bus.wr_en_0   = wr_en_0_reg;
    assign bus.wr_en_1   = wr_en_1_reg;
    assign bus.wr_addr_0 = wr_addr_0_reg;
    assign bus.wr_addr_1 = wr_addr_1_reg;
    assign bus.wr_data_0 = wr_data_0_reg;
    assign bus.wr_data_1 = wr_data_1_reg;
endmodule

// File: tb/tb_weight_buffer_loader_18_9_42_2.sv
// ---------------------------------------------------------------------------
// tb_weight_buffer_loader_18_9_42_2
//
// Drives randomized and patterned weight streams into the loader and checks
// every output on every cycle against a word-level model: accepted weights
// are counted, every 9th one closes word w, which goes to bank w%2 at
// address w/2 + 42*(w%2). A few literal expectations (strobe count, first
// and last word, done cycle, checksum totals) pin the model.
// ---------------------------------------------------------------------------
module tb_weight_buffer_loader_18_9_42_2;
    localparam int DW    = 18;
    localparam int LN    = 9;
    localparam int NROW  = 42;
    localparam int AW    = 12;
    localparam int WW    = DW * LN;
    localparam int TOTAL = 2 * NROW * LN;

    logic clk;
    logic rst_n;

    weight_buffer_loader_18_9_42_2_if #(
        .DATA_WIDTH(DW), .LANES(LN), .ADDR_WIDTH(AW)
    ) bus_if ();

    weight_buffer_loader_18_9_42_2 #(
        .DATA_WIDTH(DW), .LANES(LN), .ROWS(NROW), .ADDR_WIDTH(AW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model state: 0 idle, 1 loading, 2 done
    int          m_phase;
    int          m_count;
    logic [31:0] m_sum;
    logic [WW-1:0] m_word;
    logic          exp_en0, exp_en1;
    logic [AW-1:0] exp_addr0, exp_addr1;
    logic [WW-1:0] exp_data0, exp_data1;

    // observations from the current load
    int            ev_count;
    int            first_bank, first_addr, last_bank, last_addr, last_rel;
    logic [WW-1:0] first_data, last_data;
    int            done_rel;
    logic [31:0]   done_checksum;
    int            start_cyc;
    logic [DW-1:0] first_weights [LN];
    int            n_acc;

    task automatic chk(input string name, input logic [WW-1:0] act,
                       input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_count   = 0;
        m_sum     = '0;
        m_word    = '0;
        exp_en0   = 1'b0;
        exp_en1   = 1'b0;
        exp_addr0 = '0;
        exp_addr1 = '0;
        exp_data0 = '0;
        exp_data1 = '0;
    endtask

    // Advance the model across the edge that just happened, using the
    // inputs that were present at that edge.
    task automatic model_step();
        int k;
        int w;
        if (!rst_n) begin
            model_reset();
            return;
        end
        exp_en0 = 1'b0;
        exp_en1 = 1'b0;
        case (m_phase)
            0: if (bus_if.start) begin
                m_phase = 1;
                m_count = 0;
                m_sum   = '0;
            end
            1: if (bus_if.in_valid) begin
                k = m_count % LN;
                m_word[DW*k +: DW] = bus_if.in_data;
                m_count++;
                m_sum = m_sum + 32'(bus_if.in_data);
                if (m_count % LN == 0) begin
                    w = m_count / LN - 1;
                    if (w % 2 == 0) begin
                        exp_en0   = 1'b1;
                        exp_addr0 = AW'(w / 2);
                        exp_data0 = m_word;
                    end else begin
                        exp_en1   = 1'b1;
                        exp_addr1 = AW'(w / 2 + NROW);
                        exp_data1 = m_word;
                    end
                end
                if (m_count == TOTAL) m_phase = 2;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_step();
    endtask

    task automatic check_outputs();
        logic [31:0] exp_ck;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        exp_ck = m_sum;
`else
        exp_ck = 32'd0;
`endif
        chk("in_ready",  WW'(bus_if.in_ready),  WW'(m_phase == 1));
        chk("busy",      WW'(bus_if.busy),      WW'(m_phase != 0));
        chk("done",      WW'(bus_if.done),      WW'(m_phase == 2));
        chk("wr_en_0",   WW'(bus_if.wr_en_0),   WW'(exp_en0));
        chk("wr_en_1",   WW'(bus_if.wr_en_1),   WW'(exp_en1));
        chk("wr_addr_0", WW'(bus_if.wr_addr_0), WW'(exp_addr0));
        chk("wr_addr_1", WW'(bus_if.wr_addr_1), WW'(exp_addr1));
        chk("wr_data_0", bus_if.wr_data_0,      exp_data0);
        chk("wr_data_1", bus_if.wr_data_1,      exp_data1);
        chk("checksum",  WW'(bus_if.checksum),  WW'(exp_ck));
        if (bus_if.wr_en_0 === 1'b1 || bus_if.wr_en_1 === 1'b1) begin
            last_bank = (bus_if.wr_en_1 === 1'b1) ? 1 : 0;
            last_addr = last_bank ? int'(bus_if.wr_addr_1) : int'(bus_if.wr_addr_0);
            last_data = last_bank ? bus_if.wr_data_1 : bus_if.wr_data_0;
            last_rel  = cyc - start_cyc;
            if (ev_count == 0) begin
                first_bank = last_bank;
                first_addr = last_addr;
                first_data = last_data;
            end
            ev_count++;
        end
        if (bus_if.done === 1'b1) begin
            done_rel      = cyc - start_cyc;
            done_checksum = bus_if.checksum;
        end
    endtask

    function automatic logic [DW-1:0] pattern(input int pat, input int n);
        case (pat)
            0:       return DW'(n);
            1:       return {DW{1'b1}};
            default: return DW'($urandom);
        endcase
    endfunction

    // vmode: 0 continuous valid, 1 valid on odd cycles, 2 random valid.
    // abort_at >= 0 pulls rst_n low in that cycle of the load.
    task automatic run_load(input int vmode, input int pat, input bit extra_start,
                            input int abort_at);
        bit v;
        bit finished;
        int n;
        ev_count  = 0;
        done_rel  = -1;
        n_acc     = 0;
        n         = 0;
        finished  = 1'b0;
        start_cyc = cyc + 1;
        for (int rel = 0; rel < 4000; rel++) begin
            tick();
            if (rel == abort_at) begin
                rst_n           = 1'b0;
                model_reset();
                bus_if.start    = 1'b0;
                bus_if.in_valid = 1'b0;
                @(negedge clk);
                check_outputs();
                return;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (rel % 2 == 1);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus_if.start    = (rel == 0) || (extra_start && (rel == 100 || rel == 757));
            bus_if.in_valid = v;
            if (v && m_phase == 1) begin
                bus_if.in_data = pattern(pat, n);
                if (n_acc < LN) first_weights[n_acc] = bus_if.in_data;
                n_acc++;
                n++;
            end else begin
                bus_if.in_data = DW'($urandom);
            end
            @(negedge clk);
            check_outputs();
            if (rel > 1 && m_phase == 0) begin
                finished = 1'b1;
                break;
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL load_timeout: got running expected idle");
        end
        bus_if.start    = 1'b0;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int count, input logic rst_val);
        for (int i = 0; i < count; i++) begin
            tick();
            rst_n           = rst_val;
            if (!rst_val) model_reset();
            bus_if.start    = 1'b0;
            bus_if.in_valid = 1'($urandom_range(0, 1));
            bus_if.in_data  = DW'($urandom);
            @(negedge clk);
            check_outputs();
        end
    endtask

    initial begin
        logic [WW-1:0] ref_word;
        logic [31:0]   ck_n, ck_ones;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        ck_n    = 32'd285390;
        ck_ones = 32'd198180108;
`else
        ck_n    = 32'd0;
        ck_ones = 32'd0;
`endif
        rst_n           = 1'b0;
        bus_if.start    = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        model_reset();
        @(negedge clk);
        check_outputs();
        idle_cycles(3, 1'b0);
        idle_cycles(3, 1'b1);

        // continuous load, in_data = n
        run_load(0, 0, 1'b0, -1);
        for (int k = 0; k < LN; k++) ref_word[DW*k +: DW] = DW'(k);
        chk("cont_strobes",    WW'(ev_count),   WW'(84));
        chk("cont_first_bank", WW'(first_bank), WW'(0));
        chk("cont_first_addr", WW'(first_addr), WW'(0));
        chk("cont_first_data", first_data,      ref_word);
        for (int k = 0; k < LN; k++) ref_word[DW*k +: DW] = DW'(747 + k);
        chk("cont_last_bank",  WW'(last_bank),  WW'(1));
        chk("cont_last_addr",  WW'(last_addr),  WW'(83));
        chk("cont_last_data",  last_data,       ref_word);
        chk("cont_last_cycle", WW'(last_rel),   WW'(757));
        chk("cont_done_cycle", WW'(done_rel),   WW'(757));
        chk("cont_checksum",   WW'(done_checksum), WW'(ck_n));
        idle_cycles(4, 1'b1);

        // valid every other cycle
        run_load(1, 0, 1'b0, -1);
        chk("gap_strobes",    WW'(ev_count),  WW'(84));
        chk("gap_done_cycle", WW'(done_rel),  WW'(1512));
        chk("gap_last_data",  last_data,      ref_word);
        idle_cycles(2, 1'b1);

        // start pulses during LOAD and DONE are ignored
        run_load(0, 0, 1'b1, -1);
        chk("restart_strobes",    WW'(ev_count), WW'(84));
        chk("restart_done_cycle", WW'(done_rel), WW'(757));
        chk("restart_last_addr",  WW'(last_addr), WW'(83));
        idle_cycles(3, 1'b1);

        // reset mid-load, then reload with random weights
        run_load(0, 0, 1'b0, 300);
        idle_cycles(3, 1'b0);
        idle_cycles(2, 1'b1);
        run_load(0, 2, 1'b0, -1);
        for (int k = 0; k < LN; k++) ref_word[DW*k +: DW] = first_weights[k];
        chk("rst_first_bank", WW'(first_bank), WW'(0));
        chk("rst_first_addr", WW'(first_addr), WW'(0));
        chk("rst_first_data", first_data,      ref_word);
        chk("rst_done_cycle", WW'(done_rel),   WW'(757));
        idle_cycles(2, 1'b1);

        // all-ones weights
        run_load(0, 1, 1'b0, -1);
        chk("ones_first_data", first_data, {WW{1'b1}});
        chk("ones_last_data",  last_data,  {WW{1'b1}});
        chk("ones_checksum",   WW'(done_checksum), WW'(ck_ones));
        idle_cycles(2, 1'b1);

        // random valid and random data
        run_load(2, 2, 1'b0, -1);
        chk("rand_strobes", WW'(ev_count), WW'(84));
        idle_cycles(3, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
